// File: rtl/writeback_stage_pkg.sv
// ---------------------------------------------------------------------------
// writeback_stage_pkg
// Shared constants and types for the writeback stage slice.
//   DATA_W / NUM_REGS / REG_NUM_W : datapath and register-file geometry
//   OP_* : one-hot op-class encoding, bit order {str, ld, jmp, cmp, alu}
//   FLAG_* : bit positions of N, Z, C, V inside the 4-bit flags word
// ---------------------------------------------------------------------------
package writeback_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 16;
  localparam int REG_NUM_W = $clog2(NUM_REGS);

  typedef logic [4:0] op_class_t;

  localparam op_class_t OP_ALU = 5'b00001;
  localparam op_class_t OP_CMP = 5'b00010;
  localparam op_class_t OP_JMP = 5'b00100;
  localparam op_class_t OP_LD  = 5'b01000;
  localparam op_class_t OP_STR = 5'b10000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // A held instruction only waits on memory when it is exactly a load;
  // malformed op classes that happen to include the load bit retire at once.
  function automatic logic op_is_load(op_class_t op);
    return op == OP_LD;
  endfunction

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// NUM_REGS x DATA_W register file, two asynchronous read ports with write
// bypass, one synchronous write port, synchronous reset to zero.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   we, wnum, wval    : write enable / register number / write data
//   ra_num, ra_val    : read port A address / data (bypassed)
//   rb_num, rb_val    : read port B address / data (bypassed)
// ---------------------------------------------------------------------------
module regfile_2r1w
  import writeback_stage_pkg::*;
#(
  parameter int NUM_REGS = writeback_stage_pkg::NUM_REGS,
  parameter int DATA_W   = writeback_stage_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wnum,
  input  logic [DATA_W-1:0]           wval,
  input  logic [$clog2(NUM_REGS)-1:0] ra_num,
  output logic [DATA_W-1:0]           ra_val,
  input  logic [$clog2(NUM_REGS)-1:0] rb_num,
  output logic [DATA_W-1:0]           rb_val
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: every register is writable, including r0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wnum] <= wval;
    end
  end

  // A write in flight this cycle is visible to readers before it lands.
  assign ra_val = (we && (wnum == ra_num)) ? wval : regs[ra_num];
  assign rb_val = (we && (wnum == rb_num)) ? wval : regs[rb_num];

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Holds one MEM/WB entry, waits on load data when
// needed, then commits ALU/load results to the register file or compare
// flags to NZCV. Exposes two bypassed register read ports for decode and
// the wb_* tap for execute forwarding.
// Optional build macro: WRITEBACK_PERF_CNT_EN adds retire_count and
// ld_stall_count outputs.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid / in_ready        : handshake with the memory stage
//   in_rd_num, in_result,
//   in_flags, in_is_*_op       : incoming instruction fields
//   mem_val_passthrough,
//   mem_ready                  : load data and its valid strobe
//   rf_rd_{a,b}_num / _val     : decode read ports
//   wb_en, wb_num, wb_val      : register write happening this cycle
//   flags                      : architectural NZCV
//   stall_out                  : held load still waiting on memory
//   retire_count,
//   ld_stall_count             : performance counters (macro only)
// ---------------------------------------------------------------------------
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int NUM_REGS = writeback_stage_pkg::NUM_REGS,
  parameter int DATA_W   = writeback_stage_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(NUM_REGS)-1:0] in_rd_num,
  input  logic [DATA_W-1:0]           in_result,
  input  logic [3:0]                  in_flags,
  input  logic                        in_is_alu_op,
  input  logic                        in_is_cmp_op,
  input  logic                        in_is_jmp_op,
  input  logic                        in_is_ld_op,
  input  logic                        in_is_str_op,
  input  logic [DATA_W-1:0]           mem_val_passthrough,
  input  logic                        mem_ready,
  input  logic [$clog2(NUM_REGS)-1:0] rf_rd_a_num,
  input  logic [$clog2(NUM_REGS)-1:0] rf_rd_b_num,
  output logic [DATA_W-1:0]           rf_rd_a_val,
  output logic [DATA_W-1:0]           rf_rd_b_val,
  output logic                        wb_en,
  output logic [$clog2(NUM_REGS)-1:0] wb_num,
  output logic [DATA_W-1:0]           wb_val,
  output logic [3:0]                  flags,
  output logic                        stall_out
`ifdef WRITEBACK_PERF_CNT_EN
  ,
  output logic [31:0]                 retire_count,
  output logic [31:0]                 ld_stall_count
`endif
);

  logic                        ent_valid;
  logic [$clog2(NUM_REGS)-1:0] ent_rd;
  logic [DATA_W-1:0]           ent_result;
  logic [3:0]                  ent_flags;
  op_class_t                   ent_op;

  op_class_t in_op;
  logic      ent_is_ld;
  logic      complete;
  logic      accept;

  assign in_op = {in_is_str_op, in_is_ld_op, in_is_jmp_op, in_is_cmp_op, in_is_alu_op};

  assign ent_is_ld = op_is_load(ent_op);
  assign complete  = ent_valid && (!ent_is_ld || mem_ready);
  assign stall_out = ent_valid && ent_is_ld && !mem_ready;
  // Retiring and refilling happen in the same cycle, so a full slot that is
  // completing still looks ready upstream.
  assign in_ready  = !ent_valid || complete;
  assign accept    = in_valid && in_ready;

  // Entry slot: refill on accept, empty on complete, dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid  <= 1'b0;
      ent_rd     <= '0;
      ent_result <= '0;
      ent_flags  <= '0;
      ent_op     <= '0;
    end else if (accept) begin
      ent_valid  <= 1'b1;
      ent_rd     <= in_rd_num;
      ent_result <= in_result;
      ent_flags  <= in_flags;
      ent_op     <= in_op;
    end else if (complete) begin
      ent_valid  <= 1'b0;
    end
  end

  // Write request decode. Illegal op classes fall into default and retire
  // without touching any state.
  always_comb begin
    wb_en  = 1'b0;
    wb_num = '0;
    wb_val = '0;
    if (ent_valid) begin
      case (ent_op)
        OP_ALU: begin
          wb_en  = 1'b1;
          wb_num = ent_rd;
          wb_val = ent_result;
        end
        OP_LD: begin
          if (mem_ready) begin
            wb_en  = 1'b1;
            wb_num = ent_rd;
            wb_val = mem_val_passthrough;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural NZCV only moves when a compare retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (complete && (ent_op == OP_CMP)) begin
      flags <= ent_flags;
    end
  end

  regfile_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .wnum   (wb_num),
    .wval   (wb_val),
    .ra_num (rf_rd_a_num),
    .ra_val (rf_rd_a_val),
    .rb_num (rf_rd_b_num),
    .rb_val (rf_rd_b_val)
  );

`ifdef WRITEBACK_PERF_CNT_EN
  // Free-running counters; both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count   <= '0;
      ld_stall_count <= '0;
    end else begin
      if (complete) begin
        retire_count <= retire_count + 32'd1;
      end
      if (stall_out) begin
        ld_stall_count <= ld_stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Holds one MEM/WB entry. Waits on variable-latency load data, then commits:
  - ALU or load results go into the 16x32 register file.
  - Compare results go into the NZCV flags register.
- Provides two combinational register-file read ports with write bypass for decode, plus a forwarding tap for execute.

Parameters:
- NUM_REGS, 16, register-file depth; register number width is clog2(NUM_REGS) = 4.
- DATA_W, 32, register and datapath width.

Ports:
- clk  input  1  stage clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  memory stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_rd_num  input  4  destination register
- in_result  input  32  ALU result (alu ops)
- in_flags  input  4  NZCV from compare (cmp ops)
- in_is_alu_op / in_is_cmp_op / in_is_jmp_op / in_is_ld_op / in_is_str_op  input  1 each  one-hot op class
- mem_val_passthrough  input  32  load data from memory stage
- mem_ready  input  1  mem_val_passthrough valid this cycle
- rf_rd_a_num, rf_rd_b_num  input  4 each  decode read addresses
- rf_rd_a_val, rf_rd_b_val  output  32 each  read data, bypassed
- wb_en  output  1  register write occurs this cycle
- wb_num  output  4  register being written
- wb_val  output  32  value being written
- flags  output  4  architectural NZCV
- stall_out  output  1  load in stage still waiting for data

Behaviour:
- Reset (sync, rst=1 at edge):
  - entry valid=0; all 16 registers=0; flags=0.
  - Outputs after reset: in_ready=1, wb_en=0, wb_num=0, wb_val=0, stall_out=0.
- Entry: one registered slot {valid, rd_num, result, flags, op class}. Captured when in_valid && in_ready.
- complete = valid && (!is_ld || mem_ready).
- stall_out = valid && is_ld && !mem_ready.
- in_ready = !valid || complete. Combinational; no bubble between back-to-back instructions. Accept and complete may occur in the same cycle.
- Load data is captured only in the cycle mem_ready=1 while a load is held. mem_ready with no load held is ignored.
- Commit happens in the complete cycle, registered at the following edge:
  - alu: wb_en=1, wb_val=result.
  - ld: wb_en=1, wb_val=mem_val_passthrough.
  - cmp: flags<=entry flags, wb_en=0.
  - jmp, str: no state change, wb_en=0.
- wb_en, wb_num, wb_val are combinational from the entry (and from mem_val_passthrough for loads). They are zero when wb_en=0.
- Read ports:
  - val = (wb_en && wb_num==rd_num) ? wb_val : regfile[rd_num].
  - Both ports are independent; both may hit the same register.
- Illegal non-one-hot op class: treated as no-op commit (no write). Entry still retires.
- No register is hard-wired; r0 is writable.
- Reset during a pending load: entry dropped, no write, flags unchanged by that instruction.
- Latency: non-load is written 1 cycle after acceptance. Load is written in the edge at which mem_ready=1 is seen, and no earlier than 1 cycle after acceptance.

Optional Feature:
- Macro: WRITEBACK_PERF_CNT_EN.
- With the macro:
  - Adds outputs retire_count[31:0] and ld_stall_count[31:0], both reset to 0.
  - retire_count increments on every complete.
  - ld_stall_count increments on every cycle stall_out=1.
  - Both wrap modulo 2^32.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - DATA_W and REG_NUM_W constants.
  - Op-class one-hot encoding constants (ALU, CMP, JMP, LD, STR).
  - NZCV bit index constants.
- Sub-module: regfile_2r1w (NUM_REGS x DATA_W, two async read ports with write bypass, one sync write port, sync reset to zero). The stage instantiates it; the entry register and flags stay in writeback_stage.

Test Plan:
- Reset, then read r0..r15 on both ports -> all 0; flags=0; in_ready=1; wb_en=0.
- alu rd=3 result=0xDEADBEEF accepted -> next cycle wb_en=1, wb_num=3, wb_val=0xDEADBEEF; rf_rd_a_num=3 returns 0xDEADBEEF same cycle (bypass) and thereafter from storage.
- ld rd=5 with mem_ready low for 3 cycles, then high with data 0x12345678:
  - stall_out=1 and in_ready=0 for 3 cycles.
  - r5=0x12345678 after the edge.
  - A queued alu rd=6 is accepted in the same cycle the load completes.
- cmp flags=4'b1010, then jmp, then str, each with rd=2 -> flags=1010; r2 unchanged (0); wb_en never asserted.
- Back-to-back alu writes to r7: 0x1, 0x2, 0x3 on consecutive cycles -> in_ready stays 1; r7 ends at 0x3; port B sees each value bypassed.
- rst asserted while a load is stalled -> entry cleared; no write to rd; in_ready=1 the next cycle. With WRITEBACK_PERF_CNT_EN, the counters read 0.
